// File: rtl/sram_controller_pkg.sv
// Shared definitions for the MEM-stage SRAM controller: phase state
// encodings, data/counter widths and the common enable levels.
package sram_controller_pkg;

    localparam int LEN_SRAM_STATE = 2;
    localparam int LEN_SRAM_DATA  = 16;
    localparam int LEN_WAIT_CNT   = 4;

    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

    typedef enum logic [LEN_SRAM_STATE-1:0] {
        SRAM_IDLE = 2'd0,
        SRAM_LOW  = 2'd1,
        SRAM_HIGH = 2'd2,
        SRAM_DONE = 2'd3
    } sram_state_t;

endpackage

// File: rtl/sram_wait_counter.sv
// Loadable down-counter that times one half-word phase. The same counter
// is reloaded at the start of each phase; zero marks the phase's last cycle.
module sram_wait_counter
    import sram_controller_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [LEN_WAIT_CNT-1:0] load_value,
    input  logic                    count_en,
    output logic [LEN_WAIT_CNT-1:0] count,
    output logic                    zero
);

    // Load has priority; decrement stops at zero so the count never wraps.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count_en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/sram_controller.sv
// MEM-stage data-memory sequencer for a 16-bit asynchronous SRAM.
// Each 32-bit access runs as a low half-word phase then a high half-word
// phase, each WAIT_CYCLES long, with ready held low to freeze the pipeline.
// Optional feature: define SRAM_CTRL_RANGE_CHECK_EN to reject addresses
// outside the mapped window (adds the addr_error output).
module sram_controller
    import sram_controller_pkg::*;
#(
    parameter int BASE_ADDR   = 1024,
    parameter int SRAM_ADDR_W = 18,
    parameter int WAIT_CYCLES = 2,
    parameter int DEPTH_WORDS = 65536
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rd_en,
    input  logic                     wr_en,
    input  logic [31:0]              address,
    input  logic [31:0]              write_data,
    output logic [31:0]              read_data,
    output logic                     ready,
    output logic [SRAM_ADDR_W-1:0]   sram_addr,
    output logic [LEN_SRAM_DATA-1:0] sram_dq_out,
    output logic                     sram_dq_oe,
    input  logic [LEN_SRAM_DATA-1:0] sram_dq_in,
    output logic                     sram_we_n
`ifdef SRAM_CTRL_RANGE_CHECK_EN
    ,
    output logic                     addr_error
`endif
);

    localparam logic [LEN_WAIT_CNT-1:0] WAIT_RELOAD = LEN_WAIT_CNT'(WAIT_CYCLES - 1);
    localparam logic [33:0]             SPAN_BYTES  = 34'(DEPTH_WORDS) << 2;

    sram_state_t state;
    sram_state_t state_next;

    logic                     request;
    logic [31:0]              offset;
    logic                     in_window;
    logic                     range_ok;
    logic                     accept;
    logic                     op_write;
    logic [SRAM_ADDR_W-2:0]   word_q;
    logic [31:0]              wdata_q;

    logic                     cnt_load;
    logic                     cnt_en;
    logic [LEN_WAIT_CNT-1:0]  wait_cnt;
    logic                     wait_zero;
    logic                     capture_lo;
    logic                     capture_hi;

    assign request = rd_en | wr_en;

    // Byte offset into the SRAM window; wraps modulo 2^32 below BASE_ADDR.
    assign offset    = address - 32'(BASE_ADDR);
    assign in_window = (address >= 32'(BASE_ADDR)) && ({2'b00, offset} < SPAN_BYTES);

`ifdef SRAM_CTRL_RANGE_CHECK_EN
    assign range_ok = in_window;
    logic offset_unused;
    assign offset_unused = ^{offset[1:0]};
`else
    // Without the check the address simply wraps within the SRAM.
    assign range_ok = ENABLE;
    logic offset_unused;
    assign offset_unused = ^{offset[1:0], offset[31:SRAM_ADDR_W+1], in_window};
`endif

    sram_wait_counter u_wait_counter (
        .clk        (clk),
        .rst        (rst),
        .load       (cnt_load),
        .load_value (WAIT_RELOAD),
        .count_en   (cnt_en),
        .count      (wait_cnt),
        .zero       (wait_zero)
    );

    // Phase state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= SRAM_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state sequencing, wait counter control and read capture strobes.
    always_comb begin
        state_next = state;
        accept     = DISABLE;
        cnt_load   = DISABLE;
        cnt_en     = DISABLE;
        capture_lo = DISABLE;
        capture_hi = DISABLE;
        case (state)
            SRAM_IDLE: begin
                if (request) begin
                    accept = ENABLE;
                    if (range_ok) begin
                        state_next = SRAM_LOW;
                        cnt_load   = ENABLE;
                    end else begin
                        state_next = SRAM_DONE;
                    end
                end
            end
            SRAM_LOW: begin
                if (wait_zero) begin
                    state_next = SRAM_HIGH;
                    cnt_load   = ENABLE;
                    capture_lo = ~op_write;
                end else begin
                    cnt_en = ENABLE;
                end
            end
            SRAM_HIGH: begin
                if (wait_zero) begin
                    state_next = SRAM_DONE;
                    capture_hi = ~op_write;
                end else begin
                    cnt_en = ENABLE;
                end
            end
            SRAM_DONE: begin
                // Any request still visible here belongs to the access just finished.
                state_next = SRAM_IDLE;
            end
            default: begin
                state_next = SRAM_IDLE;
            end
        endcase
    end

    // Operation type is latched on acceptance; a simultaneous write wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_write <= DISABLE;
        end else if (accept) begin
            op_write <= wr_en;
        end
    end

    // Address and store data are held for the phases; they need no reset
    // because the pads are only driven from them outside IDLE.
    always_ff @(posedge clk) begin
        if (accept) begin
            word_q  <= offset[SRAM_ADDR_W:2];
            wdata_q <= write_data;
        end
    end

    // Load data is assembled one half-word per phase on the phase's last cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            read_data <= '0;
        end else begin
            if (capture_lo) begin
                read_data[15:0] <= sram_dq_in;
            end
            if (capture_hi) begin
                read_data[31:16] <= sram_dq_in;
            end
        end
    end

    // Pad drive decoded from the phase state; IDLE and DONE leave the bus quiet.
    always_comb begin
        sram_addr   = '0;
        sram_dq_out = '0;
        sram_dq_oe  = DISABLE;
        sram_we_n   = 1'b1;
        case (state)
            SRAM_LOW: begin
                sram_addr = {word_q, 1'b0};
                if (op_write) begin
                    sram_dq_out = wdata_q[15:0];
                    sram_dq_oe  = ENABLE;
                    sram_we_n   = 1'b0;
                end
            end
            SRAM_HIGH: begin
                sram_addr = {word_q, 1'b1};
                if (op_write) begin
                    sram_dq_out = wdata_q[31:16];
                    sram_dq_oe  = ENABLE;
                    sram_we_n   = 1'b0;
                end
            end
            default: begin
            end
        endcase
    end

    // Ready is combinational from the request so an idle pipeline never stalls.
    assign ready = ((state == SRAM_IDLE) && !request) || (state == SRAM_DONE);

`ifdef SRAM_CTRL_RANGE_CHECK_EN
    logic err_q;

    // Flag raised only for the DONE cycle of a rejected access.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= DISABLE;
        end else begin
            err_q <= accept & ~range_ok;
        end
    end

    assign addr_error = err_q;
`endif

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller with WAIT_CYCLES=2 and BASE_ADDR=1024.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_sram_controller;

    localparam int W    = 2;
    localparam int BASE = 1024;

    logic        clk;
    logic        rst;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic        sram_dq_oe;
    logic [15:0] sram_dq_in;
    logic        sram_we_n;
`ifdef SRAM_CTRL_RANGE_CHECK_EN
    logic        addr_error;
`endif

    logic [15:0] model_lo;
    logic [15:0] model_hi;

    int checks = 0;
    int errors = 0;

    sram_controller #(
        .BASE_ADDR   (BASE),
        .SRAM_ADDR_W (18),
        .WAIT_CYCLES (W),
        .DEPTH_WORDS (65536)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rd_en       (rd_en),
        .wr_en       (wr_en),
        .address     (address),
        .write_data  (write_data),
        .read_data   (read_data),
        .ready       (ready),
        .sram_addr   (sram_addr),
        .sram_dq_out (sram_dq_out),
        .sram_dq_oe  (sram_dq_oe),
        .sram_dq_in  (sram_dq_in),
        .sram_we_n   (sram_we_n)
`ifdef SRAM_CTRL_RANGE_CHECK_EN
        ,
        .addr_error  (addr_error)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM read model: even half-word address returns the low value.
    assign sram_dq_in = sram_addr[0] ? model_hi : model_lo;

    task automatic test_reset;
        rst = 1'b0; rd_en = 1'b0; wr_en = 1'b0; address = '0; write_data = '0;
        model_lo = '0; model_hi = '0;
        @(negedge clk);
        checks++; if (sram_we_n !== 1'b1) begin errors++; $display("FAIL reset_we_n got %b exp 1", sram_we_n); end
        checks++; if (sram_dq_oe !== 1'b0) begin errors++; $display("FAIL reset_oe got %b exp 0", sram_dq_oe); end
        checks++; if (read_data !== 32'h0) begin errors++; $display("FAIL reset_read_data got %h exp 0", read_data); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", ready); end
        checks++; if (sram_addr !== 18'h0) begin errors++; $display("FAIL reset_addr got %h exp 0", sram_addr); end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL idle_ready got %b exp 1", ready); end
        checks++; if (sram_we_n !== 1'b1) begin errors++; $display("FAIL idle_we_n got %b exp 1", sram_we_n); end
    endtask

    task automatic test_store;
        logic [17:0] ea;
        logic [15:0] ed;
        @(negedge clk);
        wr_en = 1'b1; address = 32'd1028; write_data = 32'hDEADBEEF;
        #1;
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL store_c0_ready got %b exp 0", ready); end
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            ea = (c <= 2) ? 18'd2 : 18'd3;
            ed = (c <= 2) ? 16'hBEEF : 16'hDEAD;
            checks++; if (ready !== (c == 5)) begin errors++; $display("FAIL store_ready c%0d got %b exp %b", c, ready, (c == 5)); end
            checks++; if (sram_we_n !== (c == 5)) begin errors++; $display("FAIL store_we_n c%0d got %b exp %b", c, sram_we_n, (c == 5)); end
            if (c <= 4) begin
                checks++; if (sram_addr !== ea) begin errors++; $display("FAIL store_addr c%0d got %h exp %h", c, sram_addr, ea); end
                checks++; if (sram_dq_out !== ed) begin errors++; $display("FAIL store_dq c%0d got %h exp %h", c, sram_dq_out, ed); end
                checks++; if (sram_dq_oe !== 1'b1) begin errors++; $display("FAIL store_oe c%0d got %b exp 1", c, sram_dq_oe); end
            end
        end
        wr_en = 1'b0;
    endtask

    task automatic test_load;
        @(negedge clk);
        model_lo = 16'hBEEF; model_hi = 16'hDEAD;
        rd_en = 1'b1; address = 32'd1028;
        #1;
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL load_c0_ready got %b exp 0", ready); end
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            checks++; if (sram_we_n !== 1'b1) begin errors++; $display("FAIL load_we_n c%0d got %b exp 1", c, sram_we_n); end
            checks++; if (sram_dq_oe !== 1'b0) begin errors++; $display("FAIL load_oe c%0d got %b exp 0", c, sram_dq_oe); end
            checks++; if (ready !== (c == 5)) begin errors++; $display("FAIL load_ready c%0d got %b exp %b", c, ready, (c == 5)); end
            if (c == 3) begin
                checks++; if (read_data !== 32'h0000BEEF) begin errors++; $display("FAIL load_half c3 got %h exp 0000beef", read_data); end
            end
            if (c == 5) begin
                checks++; if (read_data !== 32'hDEADBEEF) begin errors++; $display("FAIL load_data got %h exp deadbeef", read_data); end
            end
        end
        rd_en = 1'b0;
    endtask

    task automatic test_back_to_back;
        int ready_highs;
        ready_highs = 0;
        @(negedge clk);
        model_lo = 16'h1234; model_hi = 16'h5678;
        rd_en = 1'b1; address = 32'd1032;
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            if (c <= 10 && ready === 1'b1) ready_highs++;
            if (c == 5) begin
                checks++; if (read_data !== 32'h56781234) begin errors++; $display("FAIL b2b_load_data got %h exp 56781234", read_data); end
                rd_en = 1'b0; wr_en = 1'b1; address = 32'd1036; write_data = 32'hCAFEF00D;
            end
            if (c == 6) begin
                #1;
                checks++; if (ready !== 1'b0) begin errors++; $display("FAIL b2b_c6_ready got %b exp 0", ready); end
                checks++; if (sram_we_n !== 1'b1) begin errors++; $display("FAIL b2b_c6_we_n got %b exp 1", sram_we_n); end
            end
            if (c == 7) begin
                checks++; if (sram_we_n !== 1'b0) begin errors++; $display("FAIL b2b_c7_we_n got %b exp 0", sram_we_n); end
                checks++; if (sram_addr !== 18'd6) begin errors++; $display("FAIL b2b_c7_addr got %h exp 6", sram_addr); end
                checks++; if (sram_dq_out !== 16'hF00D) begin errors++; $display("FAIL b2b_c7_dq got %h exp f00d", sram_dq_out); end
            end
            if (c == 9) begin
                checks++; if (sram_addr !== 18'd7) begin errors++; $display("FAIL b2b_c9_addr got %h exp 7", sram_addr); end
                checks++; if (sram_dq_out !== 16'hCAFE) begin errors++; $display("FAIL b2b_c9_dq got %h exp cafe", sram_dq_out); end
            end
            if (c == 11) begin
                checks++; if (ready !== 1'b1) begin errors++; $display("FAIL b2b_c11_ready got %b exp 1", ready); end
                checks++; if (read_data !== 32'h56781234) begin errors++; $display("FAIL b2b_store_kept_data got %h exp 56781234", read_data); end
            end
        end
        checks++; if (ready_highs !== 1) begin errors++; $display("FAIL b2b_ready_pulses got %0d exp 1", ready_highs); end
        wr_en = 1'b0;
    endtask

    task automatic test_write_wins;
        @(negedge clk);
        model_lo = 16'hAAAA; model_hi = 16'hBBBB;
        rd_en = 1'b1; wr_en = 1'b1; address = 32'd1028; write_data = 32'h11112222;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 1) begin
                checks++; if (sram_we_n !== 1'b0) begin errors++; $display("FAIL ww_we_n got %b exp 0", sram_we_n); end
                checks++; if (sram_dq_out !== 16'h2222) begin errors++; $display("FAIL ww_dq got %h exp 2222", sram_dq_out); end
            end
            if (c == 5) begin
                checks++; if (ready !== 1'b1) begin errors++; $display("FAIL ww_ready got %b exp 1", ready); end
                checks++; if (read_data !== 32'h56781234) begin errors++; $display("FAIL ww_read_data got %h exp 56781234", read_data); end
            end
        end
        rd_en = 1'b0; wr_en = 1'b0;
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        wr_en = 1'b1; address = 32'd1028; write_data = 32'h0BADF00D;
        repeat (3) @(negedge clk);
        checks++; if (sram_we_n !== 1'b0) begin errors++; $display("FAIL rstmid_pre_we_n got %b exp 0", sram_we_n); end
        rst = 1'b0;
        #1;
        checks++; if (sram_we_n !== 1'b1) begin errors++; $display("FAIL rstmid_we_n got %b exp 1", sram_we_n); end
        checks++; if (sram_dq_oe !== 1'b0) begin errors++; $display("FAIL rstmid_oe got %b exp 0", sram_dq_oe); end
        checks++; if (sram_addr !== 18'h0) begin errors++; $display("FAIL rstmid_addr got %h exp 0", sram_addr); end
        checks++; if (read_data !== 32'h0) begin errors++; $display("FAIL rstmid_read_data got %h exp 0", read_data); end
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL rstmid_ready_req got %b exp 0", ready); end
        wr_en = 1'b0;
        #1;
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready_noreq got %b exp 1", ready); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        model_lo = 16'hBEEF; model_hi = 16'hDEAD;
        rd_en = 1'b1; address = 32'd1028;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 5) begin
                checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rstmid_load_ready got %b exp 1", ready); end
                checks++; if (read_data !== 32'hDEADBEEF) begin errors++; $display("FAIL rstmid_load_data got %h exp deadbeef", read_data); end
            end
        end
        rd_en = 1'b0;
    endtask

`ifdef SRAM_CTRL_RANGE_CHECK_EN
    task automatic test_range;
        @(negedge clk);
        rd_en = 1'b1; address = 32'd512;
        #1;
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL range_c0_ready got %b exp 0", ready); end
        checks++; if (addr_error !== 1'b0) begin errors++; $display("FAIL range_c0_err got %b exp 0", addr_error); end
        @(negedge clk);
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL range_c1_ready got %b exp 1", ready); end
        checks++; if (addr_error !== 1'b1) begin errors++; $display("FAIL range_c1_err got %b exp 1", addr_error); end
        checks++; if (sram_we_n !== 1'b1) begin errors++; $display("FAIL range_c1_we_n got %b exp 1", sram_we_n); end
        checks++; if (read_data !== 32'hDEADBEEF) begin errors++; $display("FAIL range_read_data got %h exp deadbeef", read_data); end
        rd_en = 1'b0;
        @(negedge clk);
        checks++; if (addr_error !== 1'b0) begin errors++; $display("FAIL range_c2_err got %b exp 0", addr_error); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL range_c2_ready got %b exp 1", ready); end
    endtask
`else
    task automatic test_wrap;
        logic [31:0] addrs [2];
        logic [17:0] exp_sa [2];
        addrs[0] = 32'd512;    exp_sa[0] = 18'h3FF00;
        addrs[1] = 32'd525312; exp_sa[1] = 18'h00000;
        for (int v = 0; v < 2; v++) begin
            @(negedge clk);
            rd_en = 1'b1; address = addrs[v];
            for (int c = 1; c <= 5; c++) begin
                @(negedge clk);
                if (c == 1) begin
                    checks++; if (sram_addr !== exp_sa[v]) begin errors++; $display("FAIL wrap_addr v%0d got %h exp %h", v, sram_addr, exp_sa[v]); end
                end
                if (c == 5) begin
                    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL wrap_ready v%0d got %b exp 1", v, ready); end
                end
            end
            rd_en = 1'b0;
        end
    endtask
`endif

    initial begin
        test_reset;
        test_store;
        test_load;
        test_back_to_back;
        test_write_wins;
        test_reset_mid;
`ifdef SRAM_CTRL_RANGE_CHECK_EN
        test_range;
`else
        test_wrap;
`endif
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "bench did not complete");
    end

endmodule
